// File: rtl/pipe_reg_pkg.sv
// rtl/pipe_reg_pkg.sv - shared types and helpers for the elastic pipeline register
package pipe_pkg;

   typedef enum logic {
      PIPE_LOCKSTEP = 1'b0,
      PIPE_COLLAPSE = 1'b1
   } pipe_mode_e;

   // counter width able to hold every occupancy from 0 up to depth inclusive
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// rtl/pipe_reg_if.sv - producer/consumer handshake bundle of the pipeline register
interface pipe_reg_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   // producer and consumer side, as seen by whoever drives the pipe
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   // the pipeline register itself
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/pipe_reg_stage.sv
// rtl/pipe_reg_stage.sv - one valid bit plus data register of the elastic pipe
module pipe_stage #(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             kill,
   input  logic             vin,
   input  logic [WIDTH-1:0] din,
   output logic             vout,
   output logic [WIDTH-1:0] dout
);
   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   // kill only clears the valid bit; data moves only when a real entry arrives
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (kill) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = vin;
         if (vin) begin
            data_d = din;
         end
      end
   end

   // stage register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         data_q  <= RESET_VAL;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign vout = valid_q;
   assign dout = data_q;
endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - parametrised elastic pipeline register with flush and occupancy count
module pipe_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               COLLAPSE  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   pipe_reg_if.slave               bus,
   output logic [cnt_w(DEPTH)-1:0] count
);
   localparam int              CW   = cnt_w(DEPTH);
   localparam logic [CW-1:0]   FULL = CW'(DEPTH);
   localparam pipe_mode_e      MODE = (COLLAPSE != 0) ? PIPE_COLLAPSE : PIPE_LOCKSTEP;

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH:0]   rdy;
   logic             in_fire, out_fire;
   logic [CW-1:0]    count_d, count_q;

   if (DEPTH < 1) begin : g_depth_chk
      $error("pipe_reg: DEPTH must be at least 1");
   end

   // ready chain, walked from the consumer back towards stage 0
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = bus.out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (MODE == PIPE_COLLAPSE) begin
            rdy[k] = !valid[k] || rdy[k+1];
         end else begin
            rdy[k] = bus.out_ready;
         end
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             vin;
      logic [WIDTH-1:0] din;
      if (k == 0) begin : g_head
         assign vin = bus.in_valid;
         assign din = bus.in_data;
      end else begin : g_body
         assign vin = valid[k-1];
         assign din = data[k-1];
      end
      pipe_stage #(
         .WIDTH     (WIDTH),
         .RESET_VAL (RESET_VAL)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .load  (rdy[k]),
         .kill  (flush),
         .vin   (vin),
         .din   (din),
         .vout  (valid[k]),
         .dout  (data[k])
      );
   end

   // in_ready is held low during reset so nothing is accepted before release
   assign bus.in_ready  = rdy[0] && !flush && reset;
   assign bus.out_valid = valid[DEPTH-1] && !flush;
   assign bus.out_data  = data[DEPTH-1];
   assign in_fire       = bus.in_valid && bus.in_ready;
   assign out_fire      = bus.out_valid && bus.out_ready;

   // occupancy: flush empties the pipe, otherwise follow the two fires
   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CW'(in_fire) - CW'(out_fire);
      end
   end

   // occupancy register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

   a_count_max: assert property (@(posedge clk) disable iff (!reset) count_q <= FULL);
   a_no_underflow: assert property (@(posedge clk) disable iff (!reset) (count_q == '0) |-> !out_fire);
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) (count_q == FULL) |-> !(in_fire && !out_fire));
   a_no_fire_on_flush: assert property (@(posedge clk) disable iff (!reset) flush |-> !out_fire);
endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - self-checking bench for pipe_reg against a slot-position queue model
module tb_pipe_reg;
   logic       clk;
   logic       reset;
   logic       flush3, flushl, flush1;
   logic [1:0] count3, countl;
   logic [0:0] count1;
   int         n_checks = 0;
   int         n_pass   = 0;

   typedef struct {
      logic [7:0] d;
      int         pos;
   } ent_t;

   ent_t mq_c[$];
   ent_t mq_l[$];

   pipe_reg_if #(.WIDTH(8)) b3 ();
   pipe_reg_if #(.WIDTH(8)) bl ();
   pipe_reg_if #(.WIDTH(8)) b1 ();

   pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .COLLAPSE(1)) dut3 (
      .clk(clk), .reset(reset), .flush(flush3), .bus(b3), .count(count3));
   pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00), .COLLAPSE(0)) dutl (
      .clk(clk), .reset(reset), .flush(flushl), .bus(bl), .count(countl));
   pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00), .COLLAPSE(1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush1), .bus(b1), .count(count1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   a_in_stable: assert property (@(posedge clk) disable iff (!reset)
      (b3.in_valid && !b3.in_ready) |=> $stable(b3.in_data));

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // one clock edge of a 3-slot pipe: oldest entry first, each entry moves up
   // as far as the slot ahead allows; lockstep moves everything only on out_ready
   task automatic model_step(input bit collapse, input bit fire, input logic [7:0] d,
                             input bit oready, input bit fl);
      ent_t q[$];
      ent_t nq[$];
      ent_t e;
      int   limit;
      if (collapse) q = mq_c; else q = mq_l;
      if (fl) begin
         q.delete();
      end else begin
         limit = 3;
         foreach (q[i]) begin
            e = q[i];
            if (e.pos == 2 && oready) continue;
            if (collapse) begin
               e.pos = (e.pos + 1 < limit) ? e.pos + 1 : limit - 1;
               limit = e.pos;
            end else if (oready) begin
               e.pos = e.pos + 1;
            end
            nq.push_back(e);
         end
         if (fire) begin
            e.d   = d;
            e.pos = 0;
            nq.push_back(e);
         end
         q = nq;
      end
      if (collapse) mq_c = q; else mq_l = q;
   endtask

   task automatic test_reset();
      n_checks++; if (b3.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", b3.out_valid); else n_pass++;
      n_checks++; if (b3.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", b3.out_data); else n_pass++;
      n_checks++; if (count3 !== 2'd0) $display("FAIL reset_count: got %0d want 0", count3); else n_pass++;
      n_checks++; if (b3.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", b3.in_ready); else n_pass++;
      n_checks++; if (bl.in_ready !== 1'b0) $display("FAIL reset_in_ready_lockstep: got %b want 0", bl.in_ready); else n_pass++;
      n_checks++; if (count1 !== 1'd0) $display("FAIL reset_count_d1: got %0d want 0", count1); else n_pass++;
   endtask

   task automatic test_streaming();
      logic [7:0] pushes [3] = '{8'h11, 8'h22, 8'h33};
      bit         ev [7]     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [7:0] ed [7]     = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
      int         ec [7]     = '{0, 1, 2, 3, 2, 1, 0};
      b3.out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         b3.in_valid = (c < 3);
         if (c < 3) b3.in_data = pushes[c];
         @(negedge clk);
         n_checks++; if (b3.out_valid !== ev[c]) $display("FAIL stream_out_valid c%0d: got %b want %b", c, b3.out_valid, ev[c]); else n_pass++;
         if (ev[c]) begin
            n_checks++; if (b3.out_data !== ed[c]) $display("FAIL stream_out_data c%0d: got %h want %h", c, b3.out_data, ed[c]); else n_pass++;
         end
         n_checks++; if (count3 !== 2'(ec[c])) $display("FAIL stream_count c%0d: got %0d want %0d", c, count3, ec[c]); else n_pass++;
         n_checks++; if (b3.in_ready !== 1'b1) $display("FAIL stream_in_ready c%0d: got %b want 1", c, b3.in_ready); else n_pass++;
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] v [4]  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      int         ec [4] = '{3, 3, 2, 1};
      b3.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b3.in_valid = 1'b1;
         b3.in_data  = v[i];
         @(negedge clk);
         n_checks++; if (b3.in_ready !== 1'b1) $display("FAIL bp_accept i%0d: got %b want 1", i, b3.in_ready); else n_pass++;
         next_cycle();
      end
      b3.in_data = v[3];
      repeat (2) begin
         @(negedge clk);
         n_checks++; if (count3 !== 2'd3) $display("FAIL bp_full_count: got %0d want 3", count3); else n_pass++;
         n_checks++; if (b3.in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b want 0", b3.in_ready); else n_pass++;
         n_checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 8'hA1) $display("FAIL bp_full_head: got %b/%h want 1/a1", b3.out_valid, b3.out_data); else n_pass++;
         next_cycle();
      end
      b3.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            n_checks++; if (b3.in_ready !== 1'b1) $display("FAIL bp_push_pop_ready: got %b want 1", b3.in_ready); else n_pass++;
         end
         n_checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== v[i]) $display("FAIL bp_drain i%0d: got %b/%h want 1/%h", i, b3.out_valid, b3.out_data, v[i]); else n_pass++;
         n_checks++; if (count3 !== 2'(ec[i])) $display("FAIL bp_drain_count i%0d: got %0d want %0d", i, count3, ec[i]); else n_pass++;
         next_cycle();
         b3.in_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++; if (count3 !== 2'd0 || b3.out_valid !== 1'b0) $display("FAIL bp_empty: got %0d/%b want 0/0", count3, b3.out_valid); else n_pass++;
      next_cycle();
   endtask

   task automatic test_collapse();
      b3.in_valid = 1'b1; b3.in_data = 8'hA1; b3.out_ready = 1'b1;
      bl.in_valid = 1'b1; bl.in_data = 8'hA1; bl.out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (b3.in_ready !== 1'b1 || bl.in_ready !== 1'b1) $display("FAIL col_first_accept: got %b/%b want 1/1", b3.in_ready, bl.in_ready); else n_pass++;
      next_cycle();
      b3.in_valid = 1'b0; b3.out_ready = 1'b0;
      bl.in_valid = 1'b0; bl.out_ready = 1'b0;
      next_cycle();
      next_cycle();
      b3.in_valid = 1'b1; b3.in_data = 8'hB2;
      bl.in_valid = 1'b1; bl.in_data = 8'hB2;
      @(negedge clk);
      n_checks++; if (b3.in_ready !== 1'b1) $display("FAIL col_b2_ready: got %b want 1", b3.in_ready); else n_pass++;
      n_checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 8'hA1) $display("FAIL col_a1_at_tail: got %b/%h want 1/a1", b3.out_valid, b3.out_data); else n_pass++;
      n_checks++; if (bl.in_ready !== 1'b0) $display("FAIL lock_b2_ready: got %b want 0", bl.in_ready); else n_pass++;
      n_checks++; if (bl.out_valid !== 1'b0) $display("FAIL lock_out_valid: got %b want 0", bl.out_valid); else n_pass++;
      next_cycle();
      b3.in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (count3 !== 2'd2) $display("FAIL col_count: got %0d want 2", count3); else n_pass++;
      n_checks++; if (countl !== 2'd1 || bl.in_ready !== 1'b0) $display("FAIL lock_count_ready: got %0d/%b want 1/0", countl, bl.in_ready); else n_pass++;
      next_cycle();
      b3.out_ready = 1'b1;
      bl.in_valid  = 1'b0;
      flushl       = 1'b1;
      @(negedge clk);
      n_checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 8'hA1) $display("FAIL col_pop_a1: got %b/%h want 1/a1", b3.out_valid, b3.out_data); else n_pass++;
      next_cycle();
      flushl = 1'b0;
      @(negedge clk);
      n_checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 8'hB2) $display("FAIL col_pop_b2: got %b/%h want 1/b2", b3.out_valid, b3.out_data); else n_pass++;
      n_checks++; if (countl !== 2'd0) $display("FAIL lock_flushed: got %0d want 0", countl); else n_pass++;
      next_cycle();
      @(negedge clk);
      n_checks++; if (count3 !== 2'd0 || b3.out_valid !== 1'b0) $display("FAIL col_empty: got %0d/%b want 0/0", count3, b3.out_valid); else n_pass++;
      next_cycle();
   endtask

   task automatic test_flush();
      logic [7:0] v [3] = '{8'hA1, 8'hB2, 8'hC3};
      b3.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b3.in_valid = 1'b1;
         b3.in_data  = v[i];
         next_cycle();
      end
      flush3 = 1'b1; b3.in_valid = 1'b1; b3.in_data = 8'h55; b3.out_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (b3.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", b3.out_valid); else n_pass++;
      n_checks++; if (b3.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", b3.in_ready); else n_pass++;
      next_cycle();
      flush3 = 1'b0; b3.in_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (count3 !== 2'd0) $display("FAIL flush_count: got %0d want 0", count3); else n_pass++;
      n_checks++; if (b3.in_ready !== 1'b1) $display("FAIL flush_ready_after: got %b want 1", b3.in_ready); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (b3.out_valid !== 1'b0) $display("FAIL flush_no_55 c%0d: got %b/%h want 0", c, b3.out_valid, b3.out_data); else n_pass++;
         next_cycle();
         @(negedge clk);
      end
      next_cycle();
   endtask

   task automatic test_random();
      bit         pend_c = 1'b0, pend_l = 1'b0;
      bit         iv_c, iv_l, or_c, or_l, fl_c, fl_l, ex_r, ex_v;
      logic [7:0] d_c = 8'h00, d_l = 8'h00;
      flush3 = 1'b1; flushl = 1'b1;
      b3.in_valid = 1'b0; bl.in_valid = 1'b0;
      next_cycle();
      mq_c.delete(); mq_l.delete();
      for (int c = 0; c < 400; c++) begin
         fl_c = ($urandom_range(0, 15) == 0);
         fl_l = ($urandom_range(0, 15) == 0);
         if (!pend_c) begin iv_c = 1'($urandom_range(0, 1)); d_c = 8'($urandom); end
         if (!pend_l) begin iv_l = 1'($urandom_range(0, 1)); d_l = 8'($urandom); end
         or_c = ($urandom_range(0, 3) != 0);
         or_l = ($urandom_range(0, 3) != 0);
         flush3 = fl_c; b3.in_valid = iv_c; b3.in_data = d_c; b3.out_ready = or_c;
         flushl = fl_l; bl.in_valid = iv_l; bl.in_data = d_l; bl.out_ready = or_l;
         @(negedge clk);
         ex_r = !fl_c && (mq_c.size() < 3 || or_c);
         ex_v = !fl_c && mq_c.size() > 0 && mq_c[0].pos == 2;
         n_checks++; if (b3.in_ready !== ex_r) $display("FAIL rnd_c_in_ready c%0d: got %b want %b", c, b3.in_ready, ex_r); else n_pass++;
         n_checks++; if (b3.out_valid !== ex_v) $display("FAIL rnd_c_out_valid c%0d: got %b want %b", c, b3.out_valid, ex_v); else n_pass++;
         n_checks++; if (count3 !== 2'(mq_c.size())) $display("FAIL rnd_c_count c%0d: got %0d want %0d", c, count3, mq_c.size()); else n_pass++;
         if (ex_v) begin
            n_checks++; if (b3.out_data !== mq_c[0].d) $display("FAIL rnd_c_out_data c%0d: got %h want %h", c, b3.out_data, mq_c[0].d); else n_pass++;
         end
         pend_c = iv_c && !ex_r;
         model_step(1'b1, iv_c && ex_r, d_c, or_c, fl_c);
         ex_r = !fl_l && or_l;
         ex_v = !fl_l && mq_l.size() > 0 && mq_l[0].pos == 2;
         n_checks++; if (bl.in_ready !== ex_r) $display("FAIL rnd_l_in_ready c%0d: got %b want %b", c, bl.in_ready, ex_r); else n_pass++;
         n_checks++; if (bl.out_valid !== ex_v) $display("FAIL rnd_l_out_valid c%0d: got %b want %b", c, bl.out_valid, ex_v); else n_pass++;
         n_checks++; if (countl !== 2'(mq_l.size())) $display("FAIL rnd_l_count c%0d: got %0d want %0d", c, countl, mq_l.size()); else n_pass++;
         if (ex_v) begin
            n_checks++; if (bl.out_data !== mq_l[0].d) $display("FAIL rnd_l_out_data c%0d: got %h want %h", c, bl.out_data, mq_l[0].d); else n_pass++;
         end
         pend_l = iv_l && !ex_r;
         model_step(1'b0, iv_l && ex_r, d_l, or_l, fl_l);
         next_cycle();
      end
      flush3 = 1'b1; flushl = 1'b1;
      b3.in_valid = 1'b0; bl.in_valid = 1'b0;
      next_cycle();
      flush3 = 1'b0; flushl = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [7:0] v [3] = '{8'hA1, 8'hB2, 8'hC3};
      b3.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         b3.in_valid = 1'b1;
         b3.in_data  = v[i];
         next_cycle();
      end
      b3.in_valid = 1'b0;
      n_checks++; if (count3 !== 2'd3) $display("FAIL rm_prefill: got %0d want 3", count3); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++; if (b3.out_valid !== 1'b0) $display("FAIL rm_out_valid: got %b want 0", b3.out_valid); else n_pass++;
      n_checks++; if (b3.out_data !== 8'h00) $display("FAIL rm_out_data: got %h want 00", b3.out_data); else n_pass++;
      n_checks++; if (count3 !== 2'd0) $display("FAIL rm_count: got %0d want 0", count3); else n_pass++;
      n_checks++; if (b3.in_ready !== 1'b0) $display("FAIL rm_in_ready: got %b want 0", b3.in_ready); else n_pass++;
      @(posedge clk);
      #1 reset = 1'b1;
      b3.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         b3.in_valid = (c == 0);
         b3.in_data  = 8'h7E;
         @(negedge clk);
         n_checks++; if (b3.out_valid !== (c == 3)) $display("FAIL rm_latency c%0d: got %b want %b", c, b3.out_valid, (c == 3)); else n_pass++;
         if (c == 3) begin
            n_checks++; if (b3.out_data !== 8'h7E) $display("FAIL rm_data: got %h want 7e", b3.out_data); else n_pass++;
         end
         next_cycle();
      end
   endtask

   task automatic test_depth1();
      int beats = 0;
      b1.out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         b1.in_valid = (c < 4);
         b1.in_data  = 8'h5A;
         @(negedge clk);
         if (b1.out_valid === 1'b1 && b1.out_data === 8'h5A) beats++;
         n_checks++; if (b1.out_valid !== (c >= 1 && c <= 4)) $display("FAIL d1_out_valid c%0d: got %b want %b", c, b1.out_valid, (c >= 1 && c <= 4)); else n_pass++;
         n_checks++; if (count1 !== 1'(c >= 1 && c <= 4)) $display("FAIL d1_count c%0d: got %0d want %0d", c, count1, (c >= 1 && c <= 4)); else n_pass++;
         n_checks++; if (b1.in_ready !== 1'b1) $display("FAIL d1_in_ready c%0d: got %b want 1", c, b1.in_ready); else n_pass++;
         next_cycle();
      end
      n_checks++; if (beats !== 4) $display("FAIL d1_beats: got %0d want 4", beats); else n_pass++;
   endtask

   initial begin
      reset  = 1'b1;
      flush3 = 1'b0; flushl = 1'b0; flush1 = 1'b0;
      b3.in_valid = 1'b0; b3.in_data = 8'h00; b3.out_ready = 1'b0;
      bl.in_valid = 1'b0; bl.in_data = 8'h00; bl.out_ready = 1'b0;
      b1.in_valid = 1'b0; b1.in_data = 8'h00; b1.out_ready = 1'b0;
      #1 reset = 1'b0;
      #1;
      test_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      test_streaming();
      test_backpressure();
      test_collapse();
      test_flush();
      test_random();
      test_reset_mid();
      test_depth1();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
